// File: rtl/seg_scan_ctrl.sv
// Binary-to-BCD display controller: sequential double-dabble conversion of a
// 16-bit write into five BCD digits, multiplexed onto a scanned 8-digit display.
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic [7:0]  digit_sel,
  output logic [3:0]  bcd_digit
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t          state, state_nx;
  logic [35:0]     sh;          // {bcd[19:0], bin[15:0]}
  logic [3:0]      iter;
  logic [15:0]     pend_data;
  logic            pend_valid;
  logic [4:0][3:0] disp;
  logic [PW-1:0]   presc;
  logic [2:0]      idx;
  logic            start;
  logic [15:0]     start_data;
  logic [4:0]      en;

  // One double-dabble iteration: adjust nibbles >= 5, then shift left.
  function automatic logic [35:0] dd_step(input logic [35:0] r);
    logic [35:0] t;
    t = r;
    for (int i = 0; i < 5; i++)
      if (t[16+4*i +: 4] >= 4'd5) t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
    return {t[34:0], 1'b0};
  endfunction

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (wr_en) state_nx = CONV;
      CONV:    if (iter == 4'd15) state_nx = LOAD;
      LOAD:    state_nx = (wr_en || pend_valid) ? CONV : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    start      = ((state == IDLE) && wr_en) || ((state == LOAD) && (wr_en || pend_valid));
    // a write landing in the LOAD cycle beats the older pending value
    start_data = wr_en ? wr_data : pend_data;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sh         <= '0;
      iter       <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      disp       <= '0;
    end else begin
      case (state)
        CONV: begin
          sh   <= dd_step(sh);
          iter <= iter + 4'd1;
          if (wr_en) begin
            pend_data  <= wr_data;
            pend_valid <= 1'b1;
          end
        end
        LOAD: begin
          disp       <= sh[35:16];
          pend_valid <= 1'b0;
        end
        default: ;
      endcase
      if (start) begin
        sh   <= {20'd0, start_data};
        iter <= '0;
      end
    end

  // free-running scan, untouched by conversion activity
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= idx + 3'd1;
    end else begin
      presc <= presc + 1'b1;
    end

  always_comb begin
    en    = '0;
    en[4] = |disp[4];
    for (int k = 3; k >= 1; k--) en[k] = en[k+1] | (|disp[k]);
    en[0] = 1'b1;
  end

  always_comb begin
    digit_sel = '0;
    bcd_digit = '0;
    case (idx)
      3'd0: begin bcd_digit = disp[0]; digit_sel = 8'h01; end
      3'd1: begin bcd_digit = disp[1]; if (en[1]) digit_sel = 8'h02; end
      3'd2: begin bcd_digit = disp[2]; if (en[2]) digit_sel = 8'h04; end
      3'd3: begin bcd_digit = disp[3]; if (en[3]) digit_sel = 8'h08; end
      3'd4: begin bcd_digit = disp[4]; if (en[4]) digit_sel = 8'h10; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=4: table of conversions plus
// hand-written pending/precedence/reset-abort sequences.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        busy;
  logic [7:0]  digit_sel;
  logic [3:0]  bcd_digit;

  seg_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy), .digit_sel(digit_sel), .bcd_digit(bcd_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // independent scan model: idx = (edges since reset / 4) mod 8
  int cyc;
  always_ff @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_idx(input int k);
    int n;
    n = 0;
    while ((((cyc >> 2) & 7) != k) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      total++;
      bad++;
      $display("FAIL idx_wait k=%0d timed out", k);
    end
  endtask

  task automatic check_scan(input string tag, input logic [19:0] digits, input logic [4:0] en);
    logic [7:0] es;
    logic [3:0] eb;
    for (int k = 0; k < 8; k++) begin
      wait_idx(k);
      es = (k < 5 && en[k]) ? (8'h01 << k) : 8'h00;
      eb = (k < 5) ? digits[4*k +: 4] : 4'h0;
      chk($sformatf("%s_sel%0d", tag, k), {24'd0, digit_sel}, {24'd0, es});
      chk($sformatf("%s_bcd%0d", tag, k), {28'd0, bcd_digit}, {28'd0, eb});
    end
  endtask

  task automatic write_wait(input logic [15:0] v, output int bc);
    @(negedge clk);
    wr_en = 1'b1; wr_data = v;
    @(negedge clk);
    wr_en = 1'b0;
    bc = 0;
    while (busy && bc < 60) begin
      bc++;
      @(negedge clk);
    end
  endtask

  logic        bh [64];
  logic [19:0] dh [64];

  // one initial write, then two extra single-cycle writes sampled at edge e+1
  task automatic run_seq(input logic [15:0] d0, input int e1, input logic [15:0] d1,
                         input int e2, input logic [15:0] d2, input int n);
    @(negedge clk);
    wr_en = 1'b1; wr_data = d0;
    for (int e = 0; e < n; e++) begin
      @(negedge clk);
      bh[e] = busy;
      dh[e] = dut.disp;
      wr_en = 1'b0;
      if (e == e1) begin wr_en = 1'b1; wr_data = d1; end
      if (e == e2) begin wr_en = 1'b1; wr_data = d2; end
    end
    wr_en = 1'b0;
  endtask

  typedef struct {
    logic [15:0] val;
    logic [19:0] digits;
    logic [4:0]  en;
  } vec_t;

  vec_t vt [6];

  initial begin
    int bc, hi, seen;
    vt[0] = '{16'd1234,  20'h01234, 5'b01111};
    vt[1] = '{16'd65535, 20'h65535, 5'b11111};
    vt[2] = '{16'd0,     20'h00000, 5'b00001};
    vt[3] = '{16'd9,     20'h00009, 5'b00001};
    vt[4] = '{16'd10000, 20'h10000, 5'b11111};
    vt[5] = '{16'd505,   20'h00505, 5'b00111};

    reset = 1'b1; wr_en = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sel", {24'd0, digit_sel}, 32'h01);
    chk("rst_bcd", {28'd0, bcd_digit}, 32'h0);
    reset = 1'b0;
    check_scan("blank", 20'h00000, 5'b00001);

    for (int i = 0; i < 6; i++) begin
      write_wait(vt[i].val, bc);
      chk($sformatf("busy_len_%0d", vt[i].val), bc, 32'd17);
      chk($sformatf("disp_%0d", vt[i].val), {12'd0, dut.disp}, {12'd0, vt[i].digits});
      check_scan($sformatf("scan_%0d", vt[i].val), vt[i].digits, vt[i].en);
    end

    // 100, then 7 and 42 while busy: newest pending wins, 7 never shown
    run_seq(16'd100, 2, 16'd7, 5, 16'd42, 40);
    hi = 0; seen = 0;
    for (int e = 0; e < 34; e++) if (bh[e]) hi++;
    for (int e = 0; e < 40; e++) if (dh[e] == 20'h00007) seen++;
    chk("pend_busy_cont", hi, 32'd34);
    chk("pend_busy_drop", {31'd0, bh[34]}, 32'd0);
    chk("pend_disp_e16", {12'd0, dh[16]}, 32'h00505);
    chk("pend_disp_e17", {12'd0, dh[17]}, 32'h00100);
    chk("pend_disp_e33", {12'd0, dh[33]}, 32'h00100);
    chk("pend_disp_e34", {12'd0, dh[34]}, 32'h00042);
    chk("pend_no7", seen, 32'd0);

    // 505 written in the LOAD cycle beats pending 77
    run_seq(16'd1234, 2, 16'd77, 16, 16'd505, 56);
    hi = 0; seen = 0;
    for (int e = 0; e < 34; e++) if (bh[e]) hi++;
    for (int e = 34; e < 56; e++) if (bh[e]) hi++;
    for (int e = 0; e < 56; e++) if (dh[e] == 20'h00077) seen++;
    chk("prec_busy", hi, 32'd34);
    chk("prec_disp_e17", {12'd0, dh[17]}, 32'h01234);
    chk("prec_disp_e34", {12'd0, dh[34]}, 32'h00505);
    chk("prec_disp_e55", {12'd0, dh[55]}, 32'h00505);
    chk("prec_no77", seen, 32'd0);

    // asynchronous reset mid-conversion of 9999
    @(negedge clk);
    wr_en = 1'b1; wr_data = 16'd9999;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sel", {24'd0, digit_sel}, 32'h01);
    chk("abort_bcd", {28'd0, bcd_digit}, 32'h0);
    chk("abort_disp", {12'd0, dut.disp}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    hi = 0;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      if (busy) hi++;
    end
    chk("abort_busy_after", hi, 32'd0);
    chk("abort_disp_after", {12'd0, dut.disp}, 32'h0);
    check_scan("abort_scan", 20'h00000, 5'b00001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
